// File: rtl/uart_rx_word_if.sv
// Bundle of the receiver's line input, baud setting and word/status outputs.
// The receiver attaches through the slave modport; its host or bench through master.
interface uart_rx_word_if #(
   parameter int N_BYT = 4,
   parameter int W_BAU = 10
);
   logic [W_BAU-1:0]   baud;
   logic               uart_rxd;
   logic [8*N_BYT-1:0] dat;
   logic               f_rcv;
   logic               f_err;
   logic               f_bsy;

   modport master (
      output baud, uart_rxd,
      input  dat, f_rcv, f_err, f_bsy
   );

   modport slave (
      input  baud, uart_rxd,
      output dat, f_rcv, f_err, f_bsy
   );
endinterface

// File: rtl/uart_rx_word.sv
// UART receiver that oversamples the line, checks framing and assembles N_BYT bytes
// (first byte most significant) into one word. Define UART_RX_TIMEOUT_EN for the inter-byte timeout.
module uart_rx_word #(
   parameter int N_BYT = 4,
   parameter int W_BAU = 10,
   parameter int N_STB = 1,
   parameter int W_TMO = 16
) (
   input logic           clk,
   input logic           rst,
   uart_rx_word_if.slave bus
);
   localparam int W_BYC = (N_BYT > 1) ? $clog2(N_BYT) : 1;
   localparam int W_STC = (N_STB > 1) ? $clog2(N_STB) : 1;
   localparam logic [W_BYC-1:0] BYT_LAST = W_BYC'(N_BYT - 1);
   localparam logic [W_STC-1:0] STB_LAST = W_STC'(N_STB - 1);

   if (N_STB < 1 || W_BAU < 3 || W_TMO < 1) begin : g_badParam
      $error("uart_rx_word: N_STB, W_BAU or W_TMO out of range");
   end

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t             r_state, w_stateNext;
   logic               r_sync1, r_sync2, r_hist;
   logic               w_fall, w_sample;
   logic [W_BAU-1:0]   r_baud, w_baudNext;
   logic [W_BAU-1:0]   r_cnt, w_cntNext;
   logic [2:0]         r_bit, w_bitNext;
   logic [W_STC-1:0]   r_stb, w_stbNext;
   logic [7:0]         r_sh, w_shNext;
   logic [W_BYC-1:0]   r_byt, w_bytNext;
   logic [8*N_BYT-1:0] r_buf, w_bufNext;
   logic [8*N_BYT-1:0] r_dat, w_datNext;
   logic               r_rcv, w_rcvNext;
   logic               r_err, w_errNext;
`ifdef UART_RX_TIMEOUT_EN
   logic [W_TMO-1:0]   r_tmo, w_tmoNext;
`endif

   assign w_fall   = !r_sync2 && r_hist;
   assign w_sample = (r_cnt == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_hist  <= 1'b1;
         r_baud  <= '0;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_stb   <= '0;
         r_sh    <= '0;
         r_byt   <= '0;
         r_buf   <= '0;
         r_dat   <= '0;
         r_rcv   <= 1'b0;
         r_err   <= 1'b0;
`ifdef UART_RX_TIMEOUT_EN
         r_tmo   <= '0;
`endif
      end else begin
         r_state <= w_stateNext;
         r_sync1 <= bus.uart_rxd;
         r_sync2 <= r_sync1;
         r_hist  <= r_sync2;
         r_baud  <= w_baudNext;
         r_cnt   <= w_cntNext;
         r_bit   <= w_bitNext;
         r_stb   <= w_stbNext;
         r_sh    <= w_shNext;
         r_byt   <= w_bytNext;
         r_buf   <= w_bufNext;
         r_dat   <= w_datNext;
         r_rcv   <= w_rcvNext;
         r_err   <= w_errNext;
`ifdef UART_RX_TIMEOUT_EN
         r_tmo   <= w_tmoNext;
`endif
      end
   end

   // The counter starts at half a bit so every sample lands mid-bit; flags are registered,
   // hence f_rcv/f_err appear the cycle after the deciding sample.
   always_comb begin
      w_stateNext = r_state;
      w_baudNext  = r_baud;
      w_cntNext   = r_cnt;
      w_bitNext   = r_bit;
      w_stbNext   = r_stb;
      w_shNext    = r_sh;
      w_bytNext   = r_byt;
      w_bufNext   = r_buf;
      w_datNext   = r_dat;
      w_rcvNext   = 1'b0;
      w_errNext   = 1'b0;
`ifdef UART_RX_TIMEOUT_EN
      w_tmoNext   = r_tmo;
`endif
      if (r_state != IDLE) begin
         w_cntNext = w_sample ? (r_baud - W_BAU'(1)) : (r_cnt - W_BAU'(1));
      end
      case (r_state)
         IDLE: begin
            if (w_fall) begin
               w_stateNext = START;
               w_baudNext  = bus.baud;
               w_cntNext   = bus.baud >> 1;
            end
`ifdef UART_RX_TIMEOUT_EN
            else if (r_byt != '0) begin
               if (r_tmo == '0) begin
                  w_bytNext = '0;
                  w_errNext = 1'b1;
               end else begin
                  w_tmoNext = r_tmo - W_TMO'(1);
               end
            end
`endif
         end
         START: begin
            if (w_sample) begin
               if (!r_sync2) begin
                  w_stateNext = DATA;
                  w_bitNext   = '0;
               end else begin
                  w_stateNext = IDLE;
                  w_bytNext   = '0;
                  w_errNext   = 1'b1;
               end
            end
         end
         DATA: begin
            if (w_sample) begin
               w_shNext = {r_sync2, r_sh[7:1]};
               if (r_bit == 3'd7) begin
                  w_stateNext = STOP;
                  w_stbNext   = '0;
               end else begin
                  w_bitNext = r_bit + 3'd1;
               end
            end
         end
         STOP: begin
            if (w_sample) begin
               if (!r_sync2) begin
                  w_stateNext = IDLE;
                  w_bytNext   = '0;
                  w_errNext   = 1'b1;
               end else if (r_stb == STB_LAST) begin
                  w_stateNext = IDLE;
                  w_bufNext[8*(N_BYT-1-int'(r_byt)) +: 8] = r_sh;
                  if (r_byt == BYT_LAST) begin
                     w_datNext = w_bufNext;
                     w_rcvNext = 1'b1;
                     w_bytNext = '0;
                  end else begin
                     w_bytNext = r_byt + W_BYC'(1);
`ifdef UART_RX_TIMEOUT_EN
                     w_tmoNext = '1;
`endif
                  end
               end else begin
                  w_stbNext = r_stb + W_STC'(1);
               end
            end
         end
         default: w_stateNext = IDLE;
      endcase
   end

   assign bus.dat   = r_dat;
   assign bus.f_rcv = r_rcv;
   assign bus.f_err = r_err;
   assign bus.f_bsy = (r_state != IDLE);
endmodule

// File: tb/tb_uart_rx_word.sv
// Directed + randomized bench for uart_rx_word: a bit-level line driver, a byte/word
// reference model built from queues, and a monitor collecting received words and error pulses.
module tb_uart_rx_word;
   localparam int N_BYT = 2;
   localparam int W_BAU = 10;
   localparam int N_STB = 2;
   localparam int W_TMO = 8;
   localparam int W_DAT = 8 * N_BYT;

   logic clk = 1'b0;
   logic rst = 1'b1;

   uart_rx_word_if #(.N_BYT(N_BYT), .W_BAU(W_BAU)) bus ();

   uart_rx_word #(
      .N_BYT(N_BYT),
      .W_BAU(W_BAU),
      .N_STB(N_STB),
      .W_TMO(W_TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every f_rcv pulse delivers one word; errors and overlaps are only counted.
   logic [W_DAT-1:0] rcvQ[$];
   int errCount  = 0;
   int bothCount = 0;
   int rcvCyc    = 0;
   int errCyc    = 0;

   always @(negedge clk) begin
      if (bus.f_rcv) begin
         rcvQ.push_back(bus.dat);
         rcvCyc <= cyc;
      end
      if (bus.f_err) begin
         errCount <= errCount + 1;
         errCyc   <= cyc;
      end
      if (bus.f_rcv && bus.f_err) bothCount <= bothCount + 1;
   end

   // Reference model: good bytes collect in order; N_BYT of them make a word, first byte on top.
   logic [7:0]       pend[$];
   logic [W_DAT-1:0] expQ[$];
   logic [W_DAT-1:0] expDat = '0;
   int expErr = 0;

   function automatic void modelByte(input logic [7:0] b, input bit good);
      logic [W_DAT-1:0] w;
      if (!good) begin
         pend.delete();
         expErr++;
         return;
      end
      pend.push_back(b);
      if (pend.size() == N_BYT) begin
         w = '0;
         foreach (pend[i]) w = (w << 8) | W_DAT'(pend[i]);
         expQ.push_back(w);
         expDat = w;
         pend.delete();
      end
   endfunction

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;
   int lastStartCyc = 0;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic idle(input int n);
      bus.uart_rxd = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // One frame: start, 8 data bits LSB first, N_STB stop bits; badStop picks a stop bit to drive low.
   task automatic applyStimulus(input logic [7:0] b, input int bd, input int badStop);
      bus.baud     = W_BAU'(bd);
      bus.uart_rxd = 1'b0;
      lastStartCyc = cyc;
      repeat (bd) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         bus.uart_rxd = b[i];
         repeat (bd) @(negedge clk);
      end
      for (int s = 0; s < N_STB; s++) begin
         bus.uart_rxd = (s == badStop) ? 1'b0 : 1'b1;
         repeat (bd) @(negedge clk);
      end
      bus.uart_rxd = 1'b1;
      modelByte(b, badStop < 0);
   endtask

   task automatic checkWords(input string tag, input int gap);
      int n;
      idle(gap);
      checkOutput({tag, "_nWords"}, 64'(rcvQ.size()), 64'(expQ.size()));
      n = (rcvQ.size() < expQ.size()) ? rcvQ.size() : expQ.size();
      for (int i = 0; i < n; i++) checkOutput({tag, "_word"}, 64'(rcvQ[i]), 64'(expQ[i]));
      checkOutput({tag, "_errs"}, 64'(errCount), 64'(expErr));
      checkOutput({tag, "_dat"}, 64'(bus.dat), 64'(expDat));
      checkOutput({tag, "_rcvErrOverlap"}, 64'(bothCount), 64'd0);
      rcvQ.delete();
      expQ.delete();
   endtask

   initial begin
      int lat, spec, gStart, bd;
      logic [7:0] b;

      bus.baud     = W_BAU'(10);
      bus.uart_rxd = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset_dat", 64'(bus.dat), 64'd0);
      checkOutput("reset_rcv", 64'(bus.f_rcv), 64'd0);
      checkOutput("reset_err", 64'(bus.f_err), 64'd0);
      checkOutput("reset_bsy", 64'(bus.f_bsy), 64'd0);
      rst = 1'b0;
      idle(5);

      $display("[TB] basic word");
      applyStimulus(8'hA5, 10, -1);
      applyStimulus(8'h3C, 10, -1);
      checkWords("basic", 40);
      checkOutput("basic_value", 64'(expDat), 64'hA53C);
      lat  = rcvCyc - lastStartCyc;
      spec = 3 + 8 * 10 + N_STB * 10 + 10 / 2;
      checkOutput("basic_latency", 64'(lat >= spec - 1 && lat <= spec + 2), 64'd1);

      $display("[TB] back-to-back words at baud 4");
      for (int w = 0; w < 6; w++) begin
         for (int k = 0; k < N_BYT; k++) applyStimulus(8'($urandom), 4, -1);
      end
      checkWords("b2b4", 30);

      $display("[TB] random baud words");
      for (int w = 0; w < 3; w++) begin
         bd = int'($urandom_range(4, 40));
         for (int k = 0; k < N_BYT; k++) applyStimulus(8'($urandom), bd, -1);
         checkWords("randBaud", 3 * bd);
      end

      $display("[TB] slow word at baud 1000");
      for (int k = 0; k < N_BYT; k++) applyStimulus(8'($urandom), 1000, -1);
      checkWords("baud1000", 2000);

      $display("[TB] glitch");
      bus.baud     = W_BAU'(20);
      bus.uart_rxd = 1'b0;
      gStart       = cyc;
      repeat (5) @(negedge clk);
      expErr++;
      idle(60);
      checkOutput("glitch_errDelay", 64'((errCyc - gStart) >= 10 && (errCyc - gStart) <= 16), 64'd1);
      for (int k = 0; k < N_BYT; k++) applyStimulus(8'($urandom), 20, -1);
      checkWords("glitch", 60);

      $display("[TB] framing error");
      applyStimulus(8'h11, 10, -1);
      applyStimulus(8'h22, 10, 1);
      idle(30);
      applyStimulus(8'h12, 10, -1);
      applyStimulus(8'h34, 10, -1);
      checkWords("framing", 40);
      checkOutput("framing_value", 64'(expDat), 64'h1234);

      $display("[TB] partial word then long idle");
      applyStimulus(8'h77, 10, -1);
      idle(300);
`ifdef UART_RX_TIMEOUT_EN
      pend.delete();
      expErr++;
      applyStimulus(8'h55, 10, -1);
      applyStimulus(8'hAA, 10, -1);
      checkWords("timeout", 40);
      checkOutput("timeout_value", 64'(expDat), 64'h55AA);
`else
      applyStimulus(8'h55, 10, -1);
      checkWords("noTimeout", 40);
      checkOutput("noTimeout_value", 64'(expDat), 64'h7755);
`endif

      $display("[TB] reset mid-frame");
      bus.baud     = W_BAU'(10);
      bus.uart_rxd = 1'b0;
      repeat (40) @(negedge clk);
      checkOutput("midFrame_bsy", 64'(bus.f_bsy), 64'd1);
      rst = 1'b1;
      #1;
      checkOutput("midReset_dat", 64'(bus.dat), 64'd0);
      checkOutput("midReset_bsy", 64'(bus.f_bsy), 64'd0);
      checkOutput("midReset_rcv", 64'(bus.f_rcv), 64'd0);
      checkOutput("midReset_err", 64'(bus.f_err), 64'd0);
      pend.delete();
      expDat = '0;
      bus.uart_rxd = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle(20);
      applyStimulus(8'hBE, 10, -1);
      applyStimulus(8'hEF, 10, -1);
      checkWords("afterReset", 40);
      checkOutput("afterReset_value", 64'(expDat), 64'hBEEF);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule

// File: doc/uart_rx_word.md
Name: uart_rx_word

Overview:
- UART receiver; the receive-side counterpart of the word transmitter. Consumes a TxD line from the host or a looped-back transmitter.
- Oversamples the line with a programmable baud count and checks framing. Assembles N_BYT consecutive bytes into one word.
- Presents the word with a one-cycle valid pulse to downstream command/register logic.
- Frame format:
  - 1 start bit (0), 8 data bits LSB first, N_STB stop bits (1), no parity.
  - The first byte received is the most significant byte of the word.

Parameters:
N_BYT, 4, number of bytes per received word
W_BAU, 10, width of baud count input and baud counter
N_STB, 1, number of stop bits checked per byte (min 1)
W_TMO, 16, width of inter-byte timeout counter (used only with UART_RX_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
baud  in  W_BAU  clock cycles per bit (min 4); sampled at each start-bit detection
uart_rxd  in  1  RxD line, asynchronous to clk, idle high
dat  out  8*N_BYT  last complete word; byte 0 received occupies dat[8*N_BYT-1 -: 8]
f_rcv  out  1  one-cycle pulse: dat updated with a new word this cycle
f_err  out  1  one-cycle pulse: framing error or false start detected, partial word discarded
f_bsy  out  1  high while a frame is in progress (start edge seen, not yet back in IDLE)

Behaviour:
- Reset: dat=0, f_rcv=0, f_err=0, f_bsy=0, FSM=IDLE, byte counter=0, both synchronizer flops=1.
- Reset asserted mid-frame aborts the frame immediately. No pulse is produced.
- Input path: 2-flop synchronizer plus one history flop. A falling edge is sync=0 while history=1.
- Baud counter:
  - On entering START, load floor(baud/2) and decrement each cycle.
  - A sample event occurs when the counter equals 0. The counter then reloads baud-1.
  - Samples are therefore exactly baud cycles apart and centred in each bit.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: f_bsy=0. A falling edge moves to START and latches baud.
  - START: at the sample event, line=0 goes to DATA with bit counter=0. Line=1 is a false start: go to IDLE and pulse f_err one cycle later.
  - DATA: each sample shifts the line into the byte shift register from the MSB side, so bits arrive LSB first. After the 8th sample go to STOP with stop counter=0.
  - STOP: each sample checks line=1.
    - Any 0 aborts the frame: byte counter clears, the partial word is discarded, f_err pulses, FSM goes to IDLE.
    - After N_STB good samples, store the byte at slot (N_BYT-1-byte_counter) and go to IDLE. Return is at mid-stop-bit, so the next start edge can be caught.
- Word completion:
  - When the stored byte is the N_BYT-th, dat is updated from the assembly buffer in the cycle after the last stop sample.
  - f_rcv is high in that same cycle, and the byte counter wraps to 0.
  - dat holds until the next complete word.
- Latency: f_rcv rises 1 clk after the final stop-bit sample event. That is 3 clk of synchronizer/edge detection plus (N_STB+8.5)*baud clk after the line edge of the last byte's start bit.
- f_rcv and f_err are never high in the same cycle.
- A break condition (line held 0) produces f_err at the first stop sample. No further activity occurs until the line returns to 1 and falls again.
- baud changes mid-frame take effect at the next start edge only.

Optional Feature:
- Macro: UART_RX_TIMEOUT_EN.
- Defined:
  - A W_TMO-bit counter is loaded with all ones on each stored byte when the byte counter is nonzero after the store. It decrements in IDLE.
  - If it reaches 0 before the next start edge, the partial word is discarded: byte counter=0 and f_err pulses one cycle.
  - The counter stops while the byte counter is 0.
- Not defined: no timeout logic. A partial word waits indefinitely for its remaining bytes.

Test Plan:
- Basic word: N_BYT=2, baud=10, send bytes 0xA5 then 0x3C, 1 stop bit -> exactly one f_rcv pulse, dat=0xA53C, f_err never high.
- Loopback with the word transmitter (N_BYT=4, baud=4 and baud=1000), random words back-to-back with no idle gap -> every word received equal to word sent, one f_rcv per word.
- Glitch: with baud=20, drive uart_rxd low for 5 clk then high -> f_err single pulse ~10 clk after edge, no f_rcv, next valid word received correctly.
- Framing error: N_STB=2, second stop bit driven 0 on byte 1 of a 2-byte word -> f_err pulse, no f_rcv. Following clean word 0x1234 -> dat=0x1234.
- Reset mid-frame: assert rst during DATA of byte 0 -> all outputs 0 immediately. After release, clean word 0xBEEF received with a single f_rcv.
- Timeout (UART_RX_TIMEOUT_EN, W_TMO=8): send one byte of a 2-byte word, idle 300 clk -> f_err pulse at ~255 clk after the byte. Next 2 bytes 0x55,0xAA -> dat=0x55AA.
